// File: rtl/noc_rr_inject_arbiter.sv
// Round-robin injection arbiter: picks one valid requester per cycle, loads it into a
// single registered output stage (optionally stamping the source ID) and counts grants per port.
module noc_rr_inject_arbiter #(
    parameter int                     N_PORTS   = 5,
    parameter int                     WIDTH     = 49,
    parameter int                     STAMP_SRC = 1,
    parameter logic [4*N_PORTS-1:0]   PORT_IDS  = 20'h43210,
    parameter int                     CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_PORTS-1:0]         in_valid,
    input  logic [N_PORTS*WIDTH-1:0]   in_data,
    output logic [N_PORTS-1:0]         in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [2:0]                 out_src,
    input  logic                       clr_cnt,
    output logic [N_PORTS*CNT_W-1:0]   grant_cnt
);

    logic                     win_found_s;
    logic [2:0]               win_idx_s;
    logic [2:0]               cand_s;
    logic                     can_load_s;
    logic                     load_s;
    logic [WIDTH-1:0]         sel_data_s;
    logic [3:0]               sel_id_s;
    logic [2:0]               rr_ptr_r;
    logic                     out_valid_r;
    logic [WIDTH-1:0]         out_data_r;
    logic [2:0]               out_src_r;
    logic [N_PORTS*CNT_W-1:0] grant_cnt_r;

    // (base + off) mod N_PORTS; both operands are below N_PORTS so one subtraction suffices
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int unsigned off);
        logic [3:0] sum;
        sum = {1'b0, base} + 4'(off);
        if (sum >= 4'(N_PORTS)) begin
            sum = sum - 4'(N_PORTS);
        end else begin
            sum = sum;
        end
        return sum[2:0];
    endfunction

    function automatic logic [WIDTH-1:0] stamp_src(input logic [WIDTH-1:0] pkt, input logic [3:0] id);
        logic [WIDTH-1:0] res;
        res = pkt;
        if (STAMP_SRC != 0) begin
            res[7:4] = id;
        end else begin
            res = pkt;
        end
        return res;
    endfunction

    assign can_load_s = ~out_valid_r | out_ready;
    assign load_s     = can_load_s & win_found_s & ~reset;

    // Scan requesters starting at rr_ptr; the first valid one wins.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        cand_s      = 3'd0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand_s = rr_index(rr_ptr_r, k);
            if (!win_found_s && in_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Select the winner's packet and its source ID.
    always_comb begin
        sel_data_s = '0;
        sel_id_s   = 4'd0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (3'(i) == win_idx_s) begin
                sel_data_s = in_data[WIDTH*i +: WIDTH];
                sel_id_s   = PORT_IDS[4*i +: 4];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    // Accept strobe: only the arbitrated winner, and only when the output stage can take it.
    always_comb begin
        in_ready = '0;
        if (load_s) begin
            in_ready[win_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Output stage and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= 3'd0;
            rr_ptr_r    <= 3'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= stamp_src(sel_data_s, sel_id_s);
            out_src_r   <= win_idx_s;
            rr_ptr_r    <= rr_index(win_idx_s, 1);
        end else if (can_load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating per-port grant counters; a clear beats a coincident grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt_r <= '0;
        end else if (clr_cnt) begin
            grant_cnt_r <= '0;
        end else if (load_s) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (3'(i) == win_idx_s && grant_cnt_r[CNT_W*i +: CNT_W] != {CNT_W{1'b1}}) begin
                    grant_cnt_r[CNT_W*i +: CNT_W] <= grant_cnt_r[CNT_W*i +: CNT_W] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    grant_cnt_r[CNT_W*i +: CNT_W] <= grant_cnt_r[CNT_W*i +: CNT_W];
                end
            end
        end else begin
            grant_cnt_r <= grant_cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;
    assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_noc_rr_inject_arbiter.sv
// Directed bench for noc_rr_inject_arbiter: default instance for arbitration/stamping,
// second instance (4-bit counters, no stamping) for saturation, clear and pass-through.
module tb_noc_rr_inject_arbiter;

    localparam int N = 5;
    localparam int W = 49;

    typedef struct {
        logic [N-1:0] valid;
        logic         ordy;
        logic [N-1:0] exp_ready;
        logic         exp_ov;
        logic [2:0]   exp_src;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   in_valid, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_ready, clr_cnt;
    logic [W-1:0]   out_data;
    logic [2:0]     out_src;
    logic [N*16-1:0] grant_cnt;

    logic [N-1:0]   in_valid_b, in_ready_b;
    logic [N*W-1:0] in_data_b;
    logic           out_valid_b, out_ready_b, clr_cnt_b;
    logic [W-1:0]   out_data_b;
    logic [2:0]     out_src_b;
    logic [N*4-1:0] grant_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_rr_inject_arbiter dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_src(out_src),
        .clr_cnt(clr_cnt), .grant_cnt(grant_cnt)
    );

    noc_rr_inject_arbiter #(.STAMP_SRC(0), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready_b), .out_src(out_src_b),
        .clr_cnt(clr_cnt_b), .grant_cnt(grant_cnt_b)
    );

    function automatic logic [W-1:0] raw_pkt(input int i);
        return {41'h1_0000_0000 + 41'(i), 4'hF, 4'(i)};
    endfunction

    function automatic logic [W-1:0] stamped_pkt(input int i);
        return {41'h1_0000_0000 + 41'(i), 4'(i), 4'(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check in_ready, clock, check output stage.
    task automatic apply_vec(input vec_t v, input int idx);
        in_valid  = v.valid;
        out_ready = v.ordy;
        #1;
        check($sformatf("in_ready[%0d]", idx), 64'(in_ready), 64'(v.exp_ready));
        @(posedge clk);
        #1;
        check($sformatf("out_valid[%0d]", idx), 64'(out_valid), 64'(v.exp_ov));
        if (v.exp_ov) begin
            check($sformatf("out_src[%0d]", idx), 64'(out_src), 64'(v.exp_src));
            check($sformatf("out_data[%0d]", idx), 64'(out_data), 64'(stamped_pkt(int'(v.exp_src))));
        end
    endtask

    task automatic check_counts(input string name, input int c0, input int c1, input int c2,
                                input int c3, input int c4);
        check({name, "_p0"}, 64'(grant_cnt[0*16 +: 16]), 64'(c0));
        check({name, "_p1"}, 64'(grant_cnt[1*16 +: 16]), 64'(c1));
        check({name, "_p2"}, 64'(grant_cnt[2*16 +: 16]), 64'(c2));
        check({name, "_p3"}, 64'(grant_cnt[3*16 +: 16]), 64'(c3));
        check({name, "_p4"}, 64'(grant_cnt[4*16 +: 16]), 64'(c4));
    endtask

    vec_t rr_vecs[10];
    vec_t pr_vecs[11];

    initial begin
        for (int i = 0; i < 10; i++) begin
            rr_vecs[i] = '{5'b11111, 1'b1, 5'(1 << (i % 5)), 1'b1, 3'(i % 5)};
        end
        pr_vecs[0]  = '{5'b11111, 1'b1, 5'b00001, 1'b1, 3'd0};
        pr_vecs[1]  = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd0};
        pr_vecs[2]  = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd0};
        pr_vecs[3]  = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd0};
        pr_vecs[4]  = '{5'b01010, 1'b0, 5'b00000, 1'b1, 3'd0};
        pr_vecs[5]  = '{5'b01010, 1'b1, 5'b00010, 1'b1, 3'd1};
        pr_vecs[6]  = '{5'b01000, 1'b1, 5'b01000, 1'b1, 3'd3};
        pr_vecs[7]  = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0};
        pr_vecs[8]  = '{5'b10000, 1'b1, 5'b10000, 1'b1, 3'd4};
        pr_vecs[9]  = '{5'b00000, 1'b1, 5'b00000, 1'b0, 3'd0};
        pr_vecs[10] = '{5'b10001, 1'b1, 5'b00001, 1'b1, 3'd0};

        reset = 1'b1;
        in_valid = '0; out_ready = 1'b1; clr_cnt = 1'b0;
        in_valid_b = '0; out_ready_b = 1'b1; clr_cnt_b = 1'b0;
        for (int i = 0; i < N; i++) begin
            in_data[W*i +: W]   = raw_pkt(i);
            in_data_b[W*i +: W] = raw_pkt(i);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_grant_cnt", 64'(grant_cnt[63:0]), 64'd0);
        reset = 1'b0;

        // Round robin with all ports requesting.
        for (int i = 0; i < 10; i++) apply_vec(rr_vecs[i], i);
        check_counts("rr_cnt", 2, 2, 2, 2, 2);

        // Leave a packet in flight with rr_ptr=2, then reset asynchronously.
        apply_vec('{5'b00010, 1'b1, 5'b00010, 1'b1, 3'd1}, 10);
        in_valid = 5'b11111;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_out_src", 64'(out_src), 64'd0);
        check_counts("midrst_cnt", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset grant from port 0, backpressure, drain, sparse traffic.
        for (int i = 0; i < 11; i++) apply_vec(pr_vecs[i], 100 + i);
        check_counts("final_cnt", 2, 1, 0, 1, 1);

        // Source stamping on the default instance.
        in_data[W*2 +: W] = 49'h1_2345_6789_AB_F5;
        in_valid = 5'b00100;
        @(posedge clk);
        #1;
        check("stamp_data", 64'(out_data), 64'h1_2345_6789_AB_25);
        check("stamp_src", 64'(out_src), 64'd2);
        in_valid = '0;

        // Pass-through on the non-stamping instance.
        in_data_b[W*2 +: W] = 49'h1_2345_6789_AB_F5;
        in_valid_b = 5'b00100;
        @(posedge clk);
        #1;
        check("nostamp_data", 64'(out_data_b), 64'h1_2345_6789_AB_F5);

        // Saturation at 4'hF after 20 grants to port 0.
        in_valid_b = 5'b00001;
        for (int i = 0; i < 20; i++) @(posedge clk);
        #1;
        check("sat_p0", 64'(grant_cnt_b[3:0]), 64'hF);
        check("sat_p2", 64'(grant_cnt_b[11:8]), 64'd1);
        in_valid_b = '0;
        clr_cnt_b = 1'b1;
        @(posedge clk);
        #1;
        check("clr_p0", 64'(grant_cnt_b[3:0]), 64'd0);
        check("clr_p2", 64'(grant_cnt_b[11:8]), 64'd0);
        in_valid_b = 5'b00001;
        @(posedge clk);
        #1;
        check("clr_with_grant", 64'(grant_cnt_b[3:0]), 64'd0);
        clr_cnt_b = 1'b0;
        @(posedge clk);
        #1;
        check("count_after_clr", 64'(grant_cnt_b[3:0]), 64'd1);
        in_valid_b = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
